ibus_rob4: RTL and testbench

IBUS_ROB4 -- requirements
Module: ibus_rob4

---
 rtl/ibus_rob4_if.sv | 36 +++
 rtl/ibus_rob4.sv | 99 +++++++++
 tb/tb_ibus_rob4.sv | 466 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ibus_rob4_if.sv
// Bundle of the upstream fetch, bus request/response and upstream response
// signals around the 4-slot instruction-bus reorder buffer.
interface ibus_rob4_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              bus_req_valid;
  logic              bus_req_ready;
  logic [ADDR_W-1:0] bus_req_addr;
  logic [1:0]        bus_req_tag;
  logic              bus_rsp_valid;
  logic [1:0]        bus_rsp_tag;
  logic [DATA_W-1:0] bus_rsp_data;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic [2:0]        occupancy;
  logic              err_unexp;

  modport slave (
    input  req_valid, req_addr, bus_req_ready,
    input  bus_rsp_valid, bus_rsp_tag, bus_rsp_data, rsp_ready,
    output req_ready, bus_req_valid, bus_req_addr, bus_req_tag,
    output rsp_valid, rsp_data, occupancy, err_unexp
  );

  modport master (
    output req_valid, req_addr, bus_req_ready,
    output bus_rsp_valid, bus_rsp_tag, bus_rsp_data, rsp_ready,
    input  req_ready, bus_req_valid, bus_req_addr, bus_req_tag,
    input  rsp_valid, rsp_data, occupancy, err_unexp
  );
endinterface

// File: rtl/ibus_rob4.sv
// Four-slot reorder buffer: issues fetches to an out-of-order bus with slot
// tags and returns the response data upstream in issue order.
module ibus_rob4 #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic        clk,
  input  logic        rst,
  ibus_rob4_if.slave  bus
);

  logic [3:0]        alloc, done;
  logic [3:0]        alloc_nxt, done_nxt;
  logic [3:0]        free_onehot;
  logic [1:0]        free_tag;
  logic              has_free;
  logic [DATA_W-1:0] slot_data [4];
  logic [1:0]        order [4];
  logic [1:0]        head, tail;
  logic [2:0]        count;
  logic              err;
  logic [1:0]        head_slot;
  logic              rsp_vld;
  logic              issue, rsp_ok, retire;

  // Lowest clear bit of alloc; all-ones wraps to zero so a full buffer gives 0000.
  assign free_onehot = ~alloc & (alloc + 4'd1);
  assign has_free    = |free_onehot;

  always_comb begin
    free_tag = 2'd0;
    case (free_onehot)
      4'b0010: free_tag = 2'd1;
      4'b0100: free_tag = 2'd2;
      4'b1000: free_tag = 2'd3;
      default: free_tag = 2'd0;
    endcase
  end

  assign bus.bus_req_valid = bus.req_valid & has_free;
  assign bus.req_ready     = bus.bus_req_ready & has_free;
  assign bus.bus_req_addr  = bus.req_addr;
  assign bus.bus_req_tag   = free_tag;

  assign head_slot    = order[head];
  assign rsp_vld      = (count != 3'd0) & done[head_slot];
  assign bus.rsp_valid = rsp_vld;
  assign bus.rsp_data  = slot_data[head_slot];

  assign issue  = bus.req_valid & has_free & bus.bus_req_ready;
  assign rsp_ok = bus.bus_rsp_valid & alloc[bus.bus_rsp_tag] & ~done[bus.bus_rsp_tag];
  assign retire = rsp_vld & bus.rsp_ready;

  assign bus.occupancy = {2'b00, alloc[0]} + {2'b00, alloc[1]}
                       + {2'b00, alloc[2]} + {2'b00, alloc[3]};
  assign bus.err_unexp = err;

  // Issue, accept and retire always touch different slots, so their updates never collide.
  always_comb begin
    alloc_nxt = alloc;
    done_nxt  = done;
    if (retire) begin
      alloc_nxt[head_slot] = 1'b0;
      done_nxt[head_slot]  = 1'b0;
    end
    if (rsp_ok) begin
      done_nxt[bus.bus_rsp_tag] = 1'b1;
    end
    if (issue) begin
      alloc_nxt[free_tag] = 1'b1;
      done_nxt[free_tag]  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alloc <= 4'd0;
      done  <= 4'd0;
      head  <= 2'd0;
      tail  <= 2'd0;
      count <= 3'd0;
      err   <= 1'b0;
    end else begin
      alloc <= alloc_nxt;
      done  <= done_nxt;
      if (issue)  tail <= tail + 2'd1;
      if (retire) head <= head + 2'd1;
      count <= count + {2'b00, issue} - {2'b00, retire};
      if (bus.bus_rsp_valid && !rsp_ok) err <= 1'b1;
    end
  end

  // Payload storage carries no reset; control state guards every read of it.
  always_ff @(posedge clk) begin
    if (rsp_ok) slot_data[bus.bus_rsp_tag] <= bus.bus_rsp_data;
    if (issue)  order[tail] <= free_tag;
  end

endmodule

// File: tb/tb_ibus_rob4.sv
// Scenario bench for ibus_rob4: expected response data is queued at issue
// time and popped as the DUT retires responses in order.
module tb_ibus_rob4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;

  ibus_rob4_if #(.ADDR_W(AW), .DATA_W(DW)) bif ();
  ibus_rob4 #(.ADDR_W(AW), .DATA_W(DW)) dut (.clk(clk), .rst(rst), .bus(bif));

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] sb [$];
  logic [DW-1:0] slot_val [4];
  logic [DW-1:0] exp_d;
  int seq = 0;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bif.req_valid     = 1'b0;
    bif.req_addr      = '0;
    bif.bus_req_ready = 1'b0;
    bif.bus_rsp_valid = 1'b0;
    bif.bus_rsp_tag   = 2'd0;
    bif.bus_rsp_data  = '0;
    bif.rsp_ready     = 1'b0;
  endtask

  function automatic logic [DW-1:0] next_val();
    seq++;
    return 32'hA000_0000 + 32'(seq);
  endfunction

  task automatic test_reset;
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
    checks++;
    if (bif.occupancy !== 3'd0 || bif.rsp_valid !== 1'b0 || bif.err_unexp !== 1'b0 || bif.bus_req_tag !== 2'd0) begin
      errors++;
      $display("FAIL reset_state occ=%0d rsp_valid=%0b err=%0b tag=%0d need 0/0/0/0",
               bif.occupancy, bif.rsp_valid, bif.err_unexp, bif.bus_req_tag);
    end
    bif.req_valid = 1'b1;
    #1;
    checks++;
    if (bif.bus_req_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_follow bus_req_valid=%0b need 1", bif.bus_req_valid);
    end
    bif.req_valid = 1'b0;
    #1;
  endtask

  task automatic test_fill;
    bif.req_valid     = 1'b1;
    bif.bus_req_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bif.req_addr = 32'h1000 + 32'(i * 4);
      #1;
      checks++;
      if (bif.bus_req_tag !== 2'(i) || bif.bus_req_valid !== 1'b1 || bif.req_ready !== 1'b1 ||
          bif.bus_req_addr !== 32'h1000 + 32'(i * 4)) begin
        errors++;
        $display("FAIL fill_issue%0d tag=%0d vld=%0b rdy=%0b addr=%h need tag=%0d 1 1 %h",
                 i, bif.bus_req_tag, bif.bus_req_valid, bif.req_ready, bif.bus_req_addr,
                 i, 32'h1000 + 32'(i * 4));
      end
      slot_val[i] = next_val();
      sb.push_back(slot_val[i]);
      step();
    end
    #1;
    checks++;
    if (bif.occupancy !== 3'd4 || bif.bus_req_valid !== 1'b0 || bif.req_ready !== 1'b0) begin
      errors++;
      $display("FAIL fill_full occ=%0d bus_req_valid=%0b req_ready=%0b need 4/0/0",
               bif.occupancy, bif.bus_req_valid, bif.req_ready);
    end
    bif.req_valid     = 1'b0;
    bif.bus_req_ready = 1'b0;
  endtask

  task automatic test_reorder;
    bif.rsp_ready     = 1'b1;
    bif.bus_rsp_valid = 1'b1;
    bif.bus_rsp_tag   = 2'd2;
    bif.bus_rsp_data  = slot_val[2];
    #1;
    checks++;
    if (bif.rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reorder_t2 rsp_valid=%0b need 0", bif.rsp_valid);
    end
    step();
    bif.bus_rsp_tag  = 2'd0;
    bif.bus_rsp_data = slot_val[0];
    #1;
    checks++;
    if (bif.rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reorder_t0 rsp_valid=%0b need 0", bif.rsp_valid);
    end
    step();
    bif.bus_rsp_tag  = 2'd3;
    bif.bus_rsp_data = slot_val[3];
    #1;
    exp_d = sb.pop_front();
    checks++;
    if (bif.rsp_valid !== 1'b1 || bif.rsp_data !== exp_d) begin
      errors++;
      $display("FAIL reorder_first rsp_valid=%0b data=%h need 1 %h", bif.rsp_valid, bif.rsp_data, exp_d);
    end
    step();
    bif.bus_rsp_tag  = 2'd1;
    bif.bus_rsp_data = slot_val[1];
    #1;
    checks++;
    if (bif.rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reorder_head_wait rsp_valid=%0b need 0", bif.rsp_valid);
    end
    step();
    bif.bus_rsp_valid = 1'b0;
    for (int c = 0; c < 12 && sb.size() > 0; c++) begin
      #1;
      if (bif.rsp_valid === 1'b1) begin
        exp_d = sb.pop_front();
        checks++;
        if (bif.rsp_data !== exp_d) begin
          errors++;
          $display("FAIL reorder_drain data=%h need %h", bif.rsp_data, exp_d);
        end
      end
      step();
    end
    checks++;
    if (sb.size() != 0 || bif.occupancy !== 3'd0) begin
      errors++;
      $display("FAIL reorder_done left=%0d occ=%0d need 0/0", sb.size(), bif.occupancy);
      sb.delete();
    end
    bif.rsp_ready = 1'b0;
  endtask

  task automatic test_hold;
    bif.req_valid     = 1'b1;
    bif.bus_req_ready = 1'b1;
    bif.req_addr      = 32'h2000;
    #1;
    checks++;
    if (bif.bus_req_tag !== 2'd0) begin
      errors++;
      $display("FAIL hold_tag tag=%0d need 0", bif.bus_req_tag);
    end
    slot_val[0] = next_val();
    sb.push_back(slot_val[0]);
    step();
    bif.req_valid     = 1'b0;
    bif.bus_req_ready = 1'b0;
    bif.rsp_ready     = 1'b0;
    bif.bus_rsp_valid = 1'b1;
    bif.bus_rsp_tag   = 2'd0;
    bif.bus_rsp_data  = slot_val[0];
    step();
    bif.bus_rsp_valid = 1'b0;
    bif.bus_rsp_data  = '0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (bif.rsp_valid !== 1'b1 || bif.rsp_data !== slot_val[0] || bif.occupancy !== 3'd1) begin
        errors++;
        $display("FAIL hold_stable%0d rsp_valid=%0b data=%h occ=%0d need 1 %h 1",
                 c, bif.rsp_valid, bif.rsp_data, bif.occupancy, slot_val[0]);
      end
      step();
    end
    bif.rsp_ready = 1'b1;
    #1;
    exp_d = sb.pop_front();
    checks++;
    if (bif.rsp_valid !== 1'b1 || bif.rsp_data !== exp_d) begin
      errors++;
      $display("FAIL hold_release rsp_valid=%0b data=%h need 1 %h", bif.rsp_valid, bif.rsp_data, exp_d);
    end
    step();
    #1;
    checks++;
    if (bif.rsp_valid !== 1'b0 || bif.occupancy !== 3'd0) begin
      errors++;
      $display("FAIL hold_retired rsp_valid=%0b occ=%0d need 0/0", bif.rsp_valid, bif.occupancy);
    end
    bif.rsp_ready = 1'b0;
  endtask

  task automatic test_full_retire;
    bif.req_valid     = 1'b1;
    bif.bus_req_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bif.req_addr = 32'h3000 + 32'(i * 4);
      #1;
      checks++;
      if (bif.bus_req_tag !== 2'(i) || bif.bus_req_valid !== 1'b1) begin
        errors++;
        $display("FAIL fr_issue%0d tag=%0d vld=%0b need %0d 1", i, bif.bus_req_tag, bif.bus_req_valid, i);
      end
      slot_val[i] = next_val();
      sb.push_back(slot_val[i]);
      step();
    end
    bif.req_valid     = 1'b0;
    bif.bus_rsp_valid = 1'b1;
    bif.bus_rsp_tag   = 2'd0;
    bif.bus_rsp_data  = slot_val[0];
    step();
    bif.bus_rsp_valid = 1'b0;
    // Cycle N: retire of slot 0 while a request waits.
    bif.req_valid = 1'b1;
    bif.req_addr  = 32'h3100;
    bif.rsp_ready = 1'b1;
    #1;
    exp_d = sb.pop_front();
    checks++;
    if (bif.bus_req_valid !== 1'b0 || bif.rsp_valid !== 1'b1 || bif.rsp_data !== exp_d) begin
      errors++;
      $display("FAIL fr_cycle_n bus_req_valid=%0b rsp_valid=%0b data=%h need 0 1 %h",
               bif.bus_req_valid, bif.rsp_valid, bif.rsp_data, exp_d);
    end
    step();
    #1;
    checks++;
    if (bif.bus_req_valid !== 1'b1 || bif.bus_req_tag !== 2'd0) begin
      errors++;
      $display("FAIL fr_cycle_n1 bus_req_valid=%0b tag=%0d need 1 0", bif.bus_req_valid, bif.bus_req_tag);
    end
    slot_val[0] = next_val();
    sb.push_back(slot_val[0]);
    step();
    bif.req_valid     = 1'b0;
    bif.bus_req_ready = 1'b0;
    bif.bus_rsp_valid = 1'b1;
    bif.bus_rsp_tag   = 2'd0;
    bif.bus_rsp_data  = slot_val[0];
    #1;
    checks++;
    if (bif.rsp_valid !== 1'b0 || bif.occupancy !== 3'd4) begin
      errors++;
      $display("FAIL fr_head_is_1 rsp_valid=%0b occ=%0d need 0 4", bif.rsp_valid, bif.occupancy);
    end
    step();
    for (int t = 1; t < 4; t++) begin
      bif.bus_rsp_tag  = 2'(t);
      bif.bus_rsp_data = slot_val[t];
      #1;
      if (bif.rsp_valid === 1'b1) begin
        exp_d = sb.pop_front();
        checks++;
        if (bif.rsp_data !== exp_d) begin
          errors++;
          $display("FAIL fr_order data=%h need %h", bif.rsp_data, exp_d);
        end
      end
      step();
    end
    bif.bus_rsp_valid = 1'b0;
    for (int c = 0; c < 12 && sb.size() > 0; c++) begin
      #1;
      if (bif.rsp_valid === 1'b1) begin
        exp_d = sb.pop_front();
        checks++;
        if (bif.rsp_data !== exp_d) begin
          errors++;
          $display("FAIL fr_drain data=%h need %h", bif.rsp_data, exp_d);
        end
      end
      step();
    end
    checks++;
    if (sb.size() != 0 || bif.occupancy !== 3'd0 || bif.err_unexp !== 1'b0) begin
      errors++;
      $display("FAIL fr_done left=%0d occ=%0d err=%0b need 0/0/0", sb.size(), bif.occupancy, bif.err_unexp);
      sb.delete();
    end
    bif.rsp_ready = 1'b0;
  endtask

  task automatic test_unexpected;
    bif.bus_rsp_valid = 1'b1;
    bif.bus_rsp_tag   = 2'd3;
    bif.bus_rsp_data  = 32'hDEAD_0003;
    step();
    bif.bus_rsp_valid = 1'b0;
    #1;
    checks++;
    if (bif.err_unexp !== 1'b1 || bif.occupancy !== 3'd0 || bif.rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL unexp_idle err=%0b occ=%0d rsp_valid=%0b need 1 0 0",
               bif.err_unexp, bif.occupancy, bif.rsp_valid);
    end
    bif.req_valid     = 1'b1;
    bif.bus_req_ready = 1'b1;
    bif.req_addr      = 32'h4000;
    slot_val[0] = next_val();
    sb.push_back(slot_val[0]);
    step();
    bif.req_valid     = 1'b0;
    bif.bus_req_ready = 1'b0;
    bif.bus_rsp_valid = 1'b1;
    bif.bus_rsp_tag   = 2'd0;
    bif.bus_rsp_data  = slot_val[0];
    step();
    bif.bus_rsp_data  = ~slot_val[0];
    step();
    bif.bus_rsp_valid = 1'b0;
    #1;
    checks++;
    if (bif.rsp_valid !== 1'b1 || bif.rsp_data !== slot_val[0] || bif.occupancy !== 3'd1 || bif.err_unexp !== 1'b1) begin
      errors++;
      $display("FAIL unexp_dup rsp_valid=%0b data=%h occ=%0d err=%0b need 1 %h 1 1",
               bif.rsp_valid, bif.rsp_data, bif.occupancy, bif.err_unexp, slot_val[0]);
    end
    bif.rsp_ready = 1'b1;
    for (int c = 0; c < 8 && sb.size() > 0; c++) begin
      #1;
      if (bif.rsp_valid === 1'b1) begin
        exp_d = sb.pop_front();
        checks++;
        if (bif.rsp_data !== exp_d) begin
          errors++;
          $display("FAIL unexp_drain data=%h need %h", bif.rsp_data, exp_d);
        end
      end
      step();
    end
    #1;
    checks++;
    if (sb.size() != 0 || bif.err_unexp !== 1'b1 || bif.occupancy !== 3'd0) begin
      errors++;
      $display("FAIL unexp_sticky left=%0d err=%0b occ=%0d need 0 1 0", sb.size(), bif.err_unexp, bif.occupancy);
      sb.delete();
    end
    bif.rsp_ready = 1'b0;
  endtask

  task automatic test_midreset;
    bif.req_valid     = 1'b1;
    bif.bus_req_ready = 1'b1;
    bif.req_addr      = 32'h5000;
    step();
    step();
    bif.req_valid     = 1'b0;
    bif.bus_req_ready = 1'b0;
    bif.bus_rsp_valid = 1'b1;
    bif.bus_rsp_tag   = 2'd0;
    bif.bus_rsp_data  = 32'h5555_0000;
    step();
    bif.bus_rsp_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    checks++;
    if (bif.occupancy !== 3'd0 || bif.rsp_valid !== 1'b0 || bif.err_unexp !== 1'b0) begin
      errors++;
      $display("FAIL midrst_state occ=%0d rsp_valid=%0b err=%0b need 0 0 0",
               bif.occupancy, bif.rsp_valid, bif.err_unexp);
    end
    bif.bus_rsp_valid = 1'b1;
    bif.bus_rsp_tag   = 2'd1;
    bif.bus_rsp_data  = 32'h5555_0001;
    step();
    bif.bus_rsp_valid = 1'b0;
    #1;
    checks++;
    if (bif.err_unexp !== 1'b1 || bif.occupancy !== 3'd0 || bif.rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_stale err=%0b occ=%0d rsp_valid=%0b need 1 0 0",
               bif.err_unexp, bif.occupancy, bif.rsp_valid);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    // Response to the tag being issued in this same cycle.
    bif.req_valid     = 1'b1;
    bif.bus_req_ready = 1'b1;
    bif.req_addr      = 32'h6000;
    bif.bus_rsp_valid = 1'b1;
    bif.bus_rsp_tag   = 2'd0;
    bif.bus_rsp_data  = 32'h6666_0000;
    #1;
    checks++;
    if (bif.bus_req_tag !== 2'd0 || bif.bus_req_valid !== 1'b1) begin
      errors++;
      $display("FAIL same_issue tag=%0d vld=%0b need 0 1", bif.bus_req_tag, bif.bus_req_valid);
    end
    slot_val[0] = next_val();
    sb.push_back(slot_val[0]);
    step();
    bif.req_valid     = 1'b0;
    bif.bus_req_ready = 1'b0;
    bif.bus_rsp_valid = 1'b0;
    #1;
    checks++;
    if (bif.err_unexp !== 1'b1 || bif.occupancy !== 3'd1 || bif.rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL same_cycle err=%0b occ=%0d rsp_valid=%0b need 1 1 0",
               bif.err_unexp, bif.occupancy, bif.rsp_valid);
    end
    bif.bus_rsp_valid = 1'b1;
    bif.bus_rsp_tag   = 2'd0;
    bif.bus_rsp_data  = slot_val[0];
    step();
    bif.bus_rsp_valid = 1'b0;
    bif.rsp_ready     = 1'b1;
    for (int c = 0; c < 8 && sb.size() > 0; c++) begin
      #1;
      if (bif.rsp_valid === 1'b1) begin
        exp_d = sb.pop_front();
        checks++;
        if (bif.rsp_data !== exp_d) begin
          errors++;
          $display("FAIL midrst_drain data=%h need %h", bif.rsp_data, exp_d);
        end
      end
      step();
    end
    checks++;
    if (sb.size() != 0 || bif.occupancy !== 3'd0) begin
      errors++;
      $display("FAIL midrst_done left=%0d occ=%0d need 0 0", sb.size(), bif.occupancy);
      sb.delete();
    end
    bif.rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    test_reset();
    test_fill();
    test_reorder();
    test_hold();
    test_full_retire();
    test_unexpected();
    test_midreset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
